// File: rtl/run_sequencer.sv
// run_sequencer: launches a processor run by holding req for REQ_CYCLES clocks, then counts
// RUN clocks until a valid ack (or, with RUN_SEQ_TIMEOUT_EN defined, a saturated counter)
// ends the run with a one-cycle done pulse and sticky status flags.
// Optional feature macro: RUN_SEQ_TIMEOUT_EN (enables the saturating-count timeout).
module run_sequencer #(
  parameter int unsigned REQ_CYCLES = 4,
  parameter int unsigned CNT_BITS   = 16,
  parameter int unsigned SEL_BITS   = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                go,
  input  logic [SEL_BITS-1:0] prog_sel,
  input  logic                ack,
  output logic                req,
  output logic [SEL_BITS-1:0] prog_id,
  output logic                busy,
  output logic                done,
  output logic                run_ok,
  output logic                run_timeout,
  output logic [CNT_BITS-1:0] cycle_count
);

  typedef enum logic [1:0] {StIdle, StStart, StRun, StFinish} state_e;

  state_e              state_q, state_d;
  logic [3:0]          req_cnt_q, req_cnt_d;
  logic                armed_q, armed_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [SEL_BITS-1:0] prog_q, prog_d;
  logic                ok_q, ok_d;
  logic                req_q, busy_q, done_q;
  logic                ack_valid;
  logic                cnt_max;
`ifdef RUN_SEQ_TIMEOUT_EN
  logic                to_q, to_d;
`endif

  // Next-state and datapath updates for the run sequence.
  always_comb begin
    state_d   = state_q;
    req_cnt_d = req_cnt_q;
    armed_d   = armed_q;
    cnt_d     = cnt_q;
    prog_d    = prog_q;
    ok_d      = ok_q;
`ifdef RUN_SEQ_TIMEOUT_EN
    to_d      = to_q;
`endif
    // A stale ack from the previous run only counts after ack has been seen low once.
    ack_valid = ack & armed_q;
    cnt_max   = &cnt_q;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          prog_d    = prog_sel;
          cnt_d     = '0;
          ok_d      = 1'b0;
`ifdef RUN_SEQ_TIMEOUT_EN
          to_d      = 1'b0;
`endif
          req_cnt_d = REQ_CYCLES[3:0];
          state_d   = StStart;
        end
      end
      StStart: begin
        req_cnt_d = req_cnt_q - 4'd1;
        if (req_cnt_q == 4'd1) begin
          armed_d = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (!cnt_max) cnt_d = cnt_q + 1'b1;
        if (!ack) armed_d = 1'b1;
        if (ack_valid) begin
          ok_d    = 1'b1;
          state_d = StFinish;
        end
`ifdef RUN_SEQ_TIMEOUT_EN
        else if (cnt_max) begin
          to_d    = 1'b1;
          state_d = StFinish;
        end
`endif
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State and registered outputs; outputs derive from the next state so they are flop-driven.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      req_cnt_q <= '0;
      armed_q   <= 1'b0;
      cnt_q     <= '0;
      prog_q    <= '0;
      ok_q      <= 1'b0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef RUN_SEQ_TIMEOUT_EN
      to_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      req_cnt_q <= req_cnt_d;
      armed_q   <= armed_d;
      cnt_q     <= cnt_d;
      prog_q    <= prog_d;
      ok_q      <= ok_d;
      req_q     <= (state_d == StStart);
      busy_q    <= (state_d != StIdle);
      done_q    <= (state_d == StFinish);
`ifdef RUN_SEQ_TIMEOUT_EN
      to_q      <= to_d;
`endif
    end
  end

  assign req         = req_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign prog_id     = prog_q;
  assign run_ok      = ok_q;
  assign cycle_count = cnt_q;
`ifdef RUN_SEQ_TIMEOUT_EN
  assign run_timeout = to_q;
`else
  assign run_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: randomized self-checking bench for run_sequencer. The expected outcome of
// each run is derived from the ack waveform using the run rules directly (first ack high that
// follows an earlier ack low in RUN, or the saturation timeout when RUN_SEQ_TIMEOUT_EN is set).
module tb_run_sequencer;

  localparam int unsigned REQ  = 4;
  localparam int unsigned CB   = 4;
  localparam int unsigned SB   = 2;
  localparam int          CMAX = (1 << CB) - 1;

  logic          clock, reset, go, ack;
  logic [SB-1:0] prog_sel;
  logic          req, busy, done, run_ok, run_timeout;
  logic [SB-1:0] prog_id;
  logic [CB-1:0] cycle_count;

  int total = 0;
  int bad   = 0;
  logic ack_seq [0:63];

  run_sequencer #(.REQ_CYCLES(REQ), .CNT_BITS(CB), .SEL_BITS(SB)) dut (
    .clock(clock), .reset(reset), .go(go), .prog_sel(prog_sel), .ack(ack), .req(req),
    .prog_id(prog_id), .busy(busy), .done(done), .run_ok(run_ok),
    .run_timeout(run_timeout), .cycle_count(cycle_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One complete run driven from ack_seq; ack_seq[i-1] is the ack level at RUN edge i.
  task automatic run_check(input logic [SB-1:0] sel, input logic start_ack, input bit noise,
                           input string name);
    int   end_i, exp_cnt, reqn;
    bit   seen0, exp_ok, exp_to, early;
    end_i = 0; seen0 = 0; exp_ok = 0; exp_to = 0; early = 0;
    for (int i = 1; i <= 64 && end_i == 0; i++) begin
      if (ack_seq[i-1] && seen0) begin
        end_i = i; exp_ok = 1;
      end
`ifdef RUN_SEQ_TIMEOUT_EN
      else if (i == CMAX + 1) begin
        end_i = i; exp_to = 1;
      end
`endif
      if (!ack_seq[i-1]) seen0 = 1;
    end
    exp_cnt = (end_i > CMAX) ? CMAX : end_i;
    if (end_i == 0) begin
      total++; bad++;
      $display("FAIL %s: stimulus never ends the run", name);
      return;
    end

    ack = start_ack; go = 1'b1; prog_sel = sel;
    tick();
    go = 1'b0;
    total++;
    if (busy !== 1'b1 || run_ok !== 1'b0 || run_timeout !== 1'b0 || cycle_count !== '0) begin
      bad++;
      $display("FAIL %s launch: busy=%0b ok=%0b to=%0b cnt=%0d want 1 0 0 0", name, busy,
               run_ok, run_timeout, cycle_count);
    end
    reqn = 0;
    while (req === 1'b1 && reqn < 20) begin
      reqn++;
      go = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      prog_sel = 2'd3;
      tick();
    end
    total++;
    if (reqn != REQ) begin
      bad++;
      $display("FAIL %s req_len: got %0d want %0d", name, reqn, REQ);
    end

    for (int i = 1; i <= end_i; i++) begin
      ack = ack_seq[i-1];
      go = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      if (i < end_i && (done !== 1'b0 || busy !== 1'b1)) early = 1;
    end
    go = 1'b0;
    total++;
    if (early) begin
      bad++;
      $display("FAIL %s early_end: got 1 want 0", name);
    end
    total++;
    if (done !== 1'b1 || run_ok !== exp_ok || run_timeout !== exp_to) begin
      bad++;
      $display("FAIL %s finish: done=%0b ok=%0b to=%0b want 1 %0b %0b", name, done, run_ok,
               run_timeout, exp_ok, exp_to);
    end
    total++;
    if (cycle_count !== CB'(exp_cnt) || prog_id !== sel) begin
      bad++;
      $display("FAIL %s count/id: cnt=%0d id=%0d want %0d %0d", name, cycle_count, prog_id,
               exp_cnt, sel);
    end
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || cycle_count !== CB'(exp_cnt) || run_ok !== exp_ok) begin
      bad++;
      $display("FAIL %s idle_hold: done=%0b busy=%0b cnt=%0d ok=%0b want 0 0 %0d %0b", name,
               done, busy, cycle_count, run_ok, exp_cnt, exp_ok);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; go = 1'b0; ack = 1'b0; prog_sel = '0;
    tick(); tick();
    reset = 1'b0;
    total++;
    if (req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctl: req=%0b busy=%0b done=%0b want 0 0 0", req, busy, done);
    end
    total++;
    if (run_ok !== 1'b0 || run_timeout !== 1'b0 || cycle_count !== '0 || prog_id !== '0) begin
      bad++;
      $display("FAIL reset_status: ok=%0b to=%0b cnt=%0d id=%0d want 0 0 0 0", run_ok,
               run_timeout, cycle_count, prog_id);
    end
  endtask

  task automatic test_normal();
    for (int i = 0; i < 64; i++) ack_seq[i] = (i >= 9);
    run_check(2'd2, 1'b0, 1'b0, "normal");
  endtask

  task automatic test_stale_ack();
    for (int i = 0; i < 64; i++) ack_seq[i] = (i != 0);
    run_check(2'd1, 1'b1, 1'b0, "stale_ack");
  endtask

  task automatic test_ignored_go();
    for (int i = 0; i < 64; i++) ack_seq[i] = (i >= 6);
    run_check(2'd1, 1'b0, 1'b1, "ignored_go");
  endtask

  task automatic test_timeout();
`ifdef RUN_SEQ_TIMEOUT_EN
    for (int i = 0; i < 64; i++) ack_seq[i] = 1'b0;
    run_check(2'd0, 1'b0, 1'b0, "timeout");
    // Valid ack on the same clock as the timeout: completion wins.
    for (int i = 0; i < 64; i++) ack_seq[i] = (i == CMAX);
    run_check(2'd3, 1'b0, 1'b0, "ack_wins");
`else
    int lows, dones;
    lows = 0; dones = 0;
    ack = 1'b0; go = 1'b1; prog_sel = 2'd0;
    tick();
    go = 1'b0;
    for (int i = 0; i < REQ; i++) tick();
    for (int i = 0; i < 120; i++) begin
      tick();
      if (busy !== 1'b1) lows++;
      if (done !== 1'b0) dones++;
    end
    total++;
    if (lows != 0 || dones != 0 || cycle_count !== CB'(CMAX) || run_timeout !== 1'b0) begin
      bad++;
      $display("FAIL no_timeout: busy_lows=%0d dones=%0d cnt=%0d to=%0b want 0 0 %0d 0", lows,
               dones, cycle_count, run_timeout, CMAX);
    end
    ack = 1'b1;
    tick();
    total++;
    if (done !== 1'b1 || run_ok !== 1'b1 || cycle_count !== CB'(CMAX)) begin
      bad++;
      $display("FAIL late_ack: done=%0b ok=%0b cnt=%0d want 1 1 %0d", done, run_ok,
               cycle_count, CMAX);
    end
    ack = 1'b0;
    tick();
`endif
  endtask

  task automatic test_reset_mid_run();
    ack = 1'b0; go = 1'b1; prog_sel = 2'd2;
    tick();
    go = 1'b0;
    for (int i = 0; i < REQ; i++) tick();
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (cycle_count !== CB'(5) || busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_run: cnt=%0d busy=%0b want 5 1", cycle_count, busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (busy !== 1'b0 || req !== 1'b0 || cycle_count !== '0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_run: busy=%0b req=%0b cnt=%0d done=%0b want 0 0 0 0", busy, req,
               cycle_count, done);
    end
    tick();
    for (int i = 0; i < 64; i++) ack_seq[i] = (i >= 3);
    run_check(2'd3, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 64; i++) ack_seq[i] = (i >= 2);
    run_check(2'd1, 1'b0, 1'b0, "b2b_first");
    for (int i = 0; i < 64; i++) ack_seq[i] = (i >= 4);
    run_check(2'd2, 1'b1, 1'b0, "b2b_second");
  endtask

  task automatic test_random();
    logic [SB-1:0] sel;
    logic          sa;
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < 64; i++) ack_seq[i] = 1'($urandom_range(0, 1));
      ack_seq[40] = 1'b0;
      ack_seq[41] = 1'b1;
      sel = SB'($urandom_range(0, 3));
      sa  = 1'($urandom_range(0, 1));
      run_check(sel, sa, 1'b1, "random");
    end
  endtask

  initial begin
    clock = 1'b0;
    reset = 1'b1;
    go = 1'b0;
    ack = 1'b0;
    prog_sel = '0;
    test_reset();
    test_normal();
    test_stale_ack();
    test_ignored_go();
    test_timeout();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
